// File: rtl/detris_pkg.sv
// Shared definitions for the Detris piece dispatch logic.
// Holds piece identifiers, the "no piece" marker and the dispatcher state encoding.
package detris_pkg;

  // Legal tetromino identifiers.
  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_e;

  // Marker for an empty hold slot or no active piece.
  localparam logic [2:0] PIECE_NONE = 3'd7;

  // Number of legal piece identifiers.
  localparam int NUM_PIECES = 7;

  // Dispatcher sequencing states.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_SPAWN = 2'd1,
    ST_PLAY  = 2'd2
  } disp_state_e;

endpackage

// File: rtl/piece_stats.sv
// Per-piece spawn statistics: one saturating counter per legal piece ID and a
// registered read port. Only built when PIECE_DISPATCHER_STATS_EN is defined.
module piece_stats #(
  parameter int PIECE_W    = 3,
  parameter int NUM_PIECES = 7,
  parameter int STAT_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_inc,
  input  logic [PIECE_W-1:0] i_inc_id,
  input  logic [PIECE_W-1:0] i_sel,
  input  logic               i_clr,
  output logic [STAT_W-1:0]  o_count
);

  logic [STAT_W-1:0] r_cnt [NUM_PIECES];
  logic [STAT_W-1:0] r_count;

  // Counter bank: clear has priority over increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PIECES; i++) begin
        r_cnt[i] <= {STAT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_PIECES; i++) begin
        if (i_clr) begin
          r_cnt[i] <= {STAT_W{1'b0}};
        end else if (i_inc && (int'(i_inc_id) == i) && (r_cnt[i] != {STAT_W{1'b1}})) begin
          r_cnt[i] <= r_cnt[i] + {{(STAT_W-1){1'b0}}, 1'b1};
        end else begin
          r_cnt[i] <= r_cnt[i];
        end
      end
    end
  end

  // Registered read mux; selectors outside the legal range read as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= {STAT_W{1'b0}};
    end else if (int'(i_sel) < NUM_PIECES) begin
      r_count <= r_cnt[i_sel];
    end else begin
      r_count <= {STAT_W{1'b0}};
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/piece_dispatcher.sv
// Piece dispatcher: consumes piece IDs from the next-piece generator, tracks the
// active piece and the hold slot (one hold per drop) and issues spawn requests
// to the playfield. Every output decodes registered state only.
// Optional per-piece spawn statistics: define PIECE_DISPATCHER_STATS_EN.
module piece_dispatcher #(
  parameter int PIECE_W    = 3,
  parameter int NUM_PIECES = 7,
  parameter int STAT_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               next_valid,
  input  logic [PIECE_W-1:0] next_piece,
  output logic               next_ready,
  input  logic               lock,
  input  logic               hold_req,
  output logic               spawn_valid,
  output logic [PIECE_W-1:0] spawn_piece,
  input  logic               spawn_ack,
`ifdef PIECE_DISPATCHER_STATS_EN
  input  logic [PIECE_W-1:0] stats_sel,
  output logic [STAT_W-1:0]  stats_count,
  input  logic               stats_clr,
`endif
  output logic [PIECE_W-1:0] active_piece,
  output logic [PIECE_W-1:0] hold_piece,
  output logic               hold_used
);

  import detris_pkg::*;

  localparam logic [PIECE_W-1:0] L_NONE = PIECE_W'(PIECE_NONE);

  // Configuration sanity: there must be room for the "none" ID above the legal range.
  if ((NUM_PIECES >= (1 << PIECE_W)) || (STAT_W < 1)) begin : g_bad_cfg
    $error("piece_dispatcher: unsupported PIECE_W/NUM_PIECES/STAT_W combination");
  end

  disp_state_e        r_state;
  disp_state_e        w_state_nxt;
  logic [PIECE_W-1:0] r_active;
  logic [PIECE_W-1:0] w_active_nxt;
  logic [PIECE_W-1:0] r_hold;
  logic [PIECE_W-1:0] w_hold_nxt;
  logic               r_hold_used;
  logic               w_hold_used_nxt;
  logic               w_legal;

  assign w_legal = (int'(next_piece) < NUM_PIECES);

  // State and datapath registers; reset abandons any pending spawn and empties hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_FETCH;
      r_active    <= L_NONE;
      r_hold      <= L_NONE;
      r_hold_used <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_active    <= w_active_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_used <= w_hold_used_nxt;
    end
  end

  // Next-state logic: fetch, spawn handshake, then play with lock/hold handling.
  always_comb begin
    w_state_nxt     = r_state;
    w_active_nxt    = r_active;
    w_hold_nxt      = r_hold;
    w_hold_used_nxt = r_hold_used;
    case (r_state)
      ST_FETCH: begin
        // Illegal IDs are popped and dropped without leaving FETCH.
        if (next_valid && w_legal) begin
          w_active_nxt = next_piece;
          w_state_nxt  = ST_SPAWN;
        end else begin
          w_state_nxt  = ST_FETCH;
        end
      end
      ST_SPAWN: begin
        if (spawn_ack) begin
          w_state_nxt = ST_PLAY;
        end else begin
          w_state_nxt = ST_SPAWN;
        end
      end
      ST_PLAY: begin
        // Lock takes priority over a simultaneous hold request.
        if (lock) begin
          w_hold_used_nxt = 1'b0;
          w_state_nxt     = ST_FETCH;
        end else if (hold_req && !r_hold_used) begin
          w_hold_used_nxt = 1'b1;
          if (r_hold == L_NONE) begin
            w_hold_nxt  = r_active;
            w_state_nxt = ST_FETCH;
          end else begin
            w_hold_nxt   = r_active;
            w_active_nxt = r_hold;
            w_state_nxt  = ST_SPAWN;
          end
        end else begin
          w_state_nxt = ST_PLAY;
        end
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  assign next_ready   = (r_state == ST_FETCH);
  assign spawn_valid  = (r_state == ST_SPAWN);
  assign spawn_piece  = r_active;
  assign active_piece = r_active;
  assign hold_piece   = r_hold;
  assign hold_used    = r_hold_used;

`ifdef PIECE_DISPATCHER_STATS_EN
  piece_stats #(
    .PIECE_W    (PIECE_W),
    .NUM_PIECES (NUM_PIECES),
    .STAT_W     (STAT_W)
  ) u_stats (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_inc    ((r_state == ST_SPAWN) && spawn_ack),
    .i_inc_id (r_active),
    .i_sel    (stats_sel),
    .i_clr    (stats_clr),
    .o_count  (stats_count)
  );
`endif

endmodule

// File: tb/tb_piece_dispatcher.sv
// Self-checking bench for piece_dispatcher: directed scenarios plus a randomized
// run compared against a behavioural model of the dispatch rules.
module tb_piece_dispatcher;

  localparam int PW = 3;
  localparam int NP = 7;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic          next_valid = 1'b0;
  logic [PW-1:0] next_piece = '0;
  logic          lock = 1'b0;
  logic          hold_req = 1'b0;
  logic          spawn_ack = 1'b0;
  logic          next_ready, spawn_valid, hold_used;
  logic [PW-1:0] spawn_piece, active_piece, hold_piece;
`ifdef PIECE_DISPATCHER_STATS_EN
  logic [PW-1:0] stats_sel = '0;
  logic          stats_clr = 1'b0;
  logic [SW-1:0] stats_count;
`endif

  int checks = 0;
  int failures = 0;

  // Behavioural model: phase 0 = waiting for a piece, 1 = spawn pending, 2 = falling.
  int            m_phase;
  logic [PW-1:0] m_active, m_hold;
  logic          m_used;
  int            m_cnt [NP];
  logic [SW-1:0] m_stat_q;

  piece_dispatcher #(.PIECE_W(PW), .NUM_PIECES(NP), .STAT_W(SW)) dut (
    .clk(clk), .reset_n(reset_n),
    .next_valid(next_valid), .next_piece(next_piece), .next_ready(next_ready),
    .lock(lock), .hold_req(hold_req),
    .spawn_valid(spawn_valid), .spawn_piece(spawn_piece), .spawn_ack(spawn_ack),
`ifdef PIECE_DISPATCHER_STATS_EN
    .stats_sel(stats_sel), .stats_count(stats_count), .stats_clr(stats_clr),
`endif
    .active_piece(active_piece), .hold_piece(hold_piece), .hold_used(hold_used)
  );

  task automatic model_reset();
    m_phase = 0; m_active = 3'd7; m_hold = 3'd7; m_used = 1'b0; m_stat_q = '0;
    for (int i = 0; i < NP; i++) m_cnt[i] = 0;
  endtask

  // Apply the dispatch rules to the inputs present at this rising edge.
  task automatic model_edge();
    logic [PW-1:0] tmp;
`ifdef PIECE_DISPATCHER_STATS_EN
    int rd;
    rd = (int'(stats_sel) < NP) ? m_cnt[stats_sel] : 0;
    m_stat_q = rd[SW-1:0];
    if (stats_clr) begin
      for (int i = 0; i < NP; i++) m_cnt[i] = 0;
    end else if (m_phase == 1 && spawn_ack && m_cnt[m_active] < (1 << SW) - 1) begin
      m_cnt[m_active] = m_cnt[m_active] + 1;
    end
`endif
    if (m_phase == 0) begin
      if (next_valid && int'(next_piece) < NP) begin m_active = next_piece; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (spawn_ack) m_phase = 2;
    end else begin
      if (lock) begin
        m_used = 1'b0; m_phase = 0;
      end else if (hold_req && !m_used) begin
        m_used = 1'b1;
        if (m_hold == 3'd7) begin
          m_hold = m_active; m_phase = 0;
        end else begin
          tmp = m_hold; m_hold = m_active; m_active = tmp; m_phase = 1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic pop(input logic [PW-1:0] p);
    next_valid = 1'b1; next_piece = p; cycle(); next_valid = 1'b0;
  endtask

  task automatic ack();
    spawn_ack = 1'b1; cycle(); spawn_ack = 1'b0;
  endtask

  task automatic pulse_lock();
    lock = 1'b1; cycle(); lock = 1'b0;
  endtask

  task automatic pulse_hold();
    hold_req = 1'b1; cycle(); hold_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (spawn_valid !== 1'b0) begin failures++; $display("FAIL reset_spawn_valid got=%b exp=0", spawn_valid); end
    checks++; if (active_piece !== 3'd7) begin failures++; $display("FAIL reset_active got=%0d exp=7", active_piece); end
    checks++; if (hold_piece !== 3'd7) begin failures++; $display("FAIL reset_hold got=%0d exp=7", hold_piece); end
    checks++; if (hold_used !== 1'b0) begin failures++; $display("FAIL reset_hold_used got=%b exp=0", hold_used); end
    reset_n = 1'b1;
    #1;
    checks++; if (next_ready !== 1'b1) begin failures++; $display("FAIL reset_next_ready got=%b exp=1", next_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic_spawn();
    pop(3'd2);
    checks++; if (spawn_valid !== 1'b1) begin failures++; $display("FAIL basic_spawn_valid got=%b exp=1", spawn_valid); end
    checks++; if (spawn_piece !== 3'd2) begin failures++; $display("FAIL basic_spawn_piece got=%0d exp=2", spawn_piece); end
    checks++; if (next_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_low got=%b exp=0", next_ready); end
    ack();
    checks++; if (spawn_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", spawn_valid); end
    checks++; if (active_piece !== 3'd2) begin failures++; $display("FAIL basic_active got=%0d exp=2", active_piece); end
  endtask

  task automatic test_hold_empty();
    pulse_hold();
    checks++; if (hold_piece !== 3'd2) begin failures++; $display("FAIL hold_piece got=%0d exp=2", hold_piece); end
    checks++; if (hold_used !== 1'b1) begin failures++; $display("FAIL hold_used got=%b exp=1", hold_used); end
    checks++; if (next_ready !== 1'b1) begin failures++; $display("FAIL hold_ready got=%b exp=1", next_ready); end
    pop(3'd5);
    checks++; if (spawn_piece !== 3'd5) begin failures++; $display("FAIL hold_pop_piece got=%0d exp=5", spawn_piece); end
    ack();
    pulse_hold();
    checks++; if (hold_piece !== 3'd2 || spawn_valid !== 1'b0 || next_ready !== 1'b0) begin
      failures++; $display("FAIL hold_second_ignored hold=%0d sv=%b nr=%b exp hold=2 sv=0 nr=0", hold_piece, spawn_valid, next_ready);
    end
  endtask

  task automatic test_swap();
    pulse_lock();
    checks++; if (hold_used !== 1'b0 || next_ready !== 1'b1) begin
      failures++; $display("FAIL lock_release used=%b nr=%b exp used=0 nr=1", hold_used, next_ready);
    end
    pop(3'd5);
    ack();
    pulse_hold();
    checks++; if (spawn_valid !== 1'b1 || spawn_piece !== 3'd2) begin
      failures++; $display("FAIL swap_spawn sv=%b piece=%0d exp sv=1 piece=2", spawn_valid, spawn_piece);
    end
    checks++; if (hold_piece !== 3'd5 || hold_used !== 1'b1 || next_ready !== 1'b0) begin
      failures++; $display("FAIL swap_hold hold=%0d used=%b nr=%b exp hold=5 used=1 nr=0", hold_piece, hold_used, next_ready);
    end
    ack();
    pulse_lock();
    checks++; if (hold_used !== 1'b0) begin failures++; $display("FAIL swap_lock_used got=%b exp=0", hold_used); end
  endtask

  task automatic test_lock_and_hold();
    pop(3'd1);
    ack();
    lock = 1'b1; hold_req = 1'b1; cycle(); lock = 1'b0; hold_req = 1'b0;
    checks++; if (hold_piece !== 3'd5 || hold_used !== 1'b0 || next_ready !== 1'b1) begin
      failures++; $display("FAIL lock_wins hold=%0d used=%b nr=%b exp hold=5 used=0 nr=1", hold_piece, hold_used, next_ready);
    end
    ack();
    checks++; if (next_ready !== 1'b1 || spawn_valid !== 1'b0) begin
      failures++; $display("FAIL ack_in_fetch nr=%b sv=%b exp nr=1 sv=0", next_ready, spawn_valid);
    end
    pop(3'd7);
    checks++; if (next_ready !== 1'b1 || spawn_valid !== 1'b0 || active_piece !== 3'd1) begin
      failures++; $display("FAIL illegal_drop nr=%b sv=%b act=%0d exp nr=1 sv=0 act=1", next_ready, spawn_valid, active_piece);
    end
    pop(3'd0);
    checks++; if (spawn_valid !== 1'b1 || spawn_piece !== 3'd0) begin
      failures++; $display("FAIL after_illegal sv=%b piece=%0d exp sv=1 piece=0", spawn_valid, spawn_piece);
    end
  endtask

  task automatic test_ack_stall_and_reset();
    next_valid = 1'b1; next_piece = 3'd4;
    for (int i = 0; i < 10; i++) begin
      lock = (i == 3); hold_req = (i == 5);
      cycle();
      checks++; if (spawn_valid !== 1'b1 || spawn_piece !== 3'd0 || hold_piece !== 3'd5 || next_ready !== 1'b0) begin
        failures++; $display("FAIL stall_stable cyc=%0d sv=%b piece=%0d hold=%0d nr=%b exp sv=1 piece=0 hold=5 nr=0", i, spawn_valid, spawn_piece, hold_piece, next_ready);
      end
    end
    lock = 1'b0; hold_req = 1'b0; next_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (spawn_valid !== 1'b0 || next_ready !== 1'b1 || active_piece !== 3'd7 || hold_piece !== 3'd7 || hold_used !== 1'b0) begin
      failures++; $display("FAIL async_reset sv=%b nr=%b act=%0d hold=%0d used=%b exp sv=0 nr=1 act=7 hold=7 used=0", spawn_valid, next_ready, active_piece, hold_piece, hold_used);
    end
    model_reset();
    #1 reset_n = 1'b1;
    cycle();
    checks++; if (spawn_valid !== 1'b0 || next_ready !== 1'b1) begin
      failures++; $display("FAIL post_reset sv=%b nr=%b exp sv=0 nr=1", spawn_valid, next_ready);
    end
  endtask

`ifdef PIECE_DISPATCHER_STATS_EN
  task automatic test_stats();
    for (int i = 0; i < 4; i++) begin pop(3'd3); ack(); pulse_lock(); end
    stats_sel = 3'd3; cycle();
    checks++; if (stats_count !== 4'd4) begin failures++; $display("FAIL stats_four got=%0d exp=4", stats_count); end
    stats_clr = 1'b1; cycle(); stats_clr = 1'b0; cycle();
    checks++; if (stats_count !== 4'd0) begin failures++; $display("FAIL stats_clear got=%0d exp=0", stats_count); end
    pop(3'd3); stats_clr = 1'b1; ack(); stats_clr = 1'b0; pulse_lock(); cycle();
    checks++; if (stats_count !== 4'd0) begin failures++; $display("FAIL stats_clr_wins got=%0d exp=0", stats_count); end
    for (int i = 0; i < 20; i++) begin pop(3'd3); ack(); pulse_lock(); end
    cycle();
    checks++; if (stats_count !== 4'hF) begin failures++; $display("FAIL stats_saturate got=%0d exp=15", stats_count); end
    stats_sel = 3'd7; cycle();
    checks++; if (stats_count !== 4'd0) begin failures++; $display("FAIL stats_bad_sel got=%0d exp=0", stats_count); end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      next_valid = ($urandom_range(0, 1) == 1);
      next_piece = PW'($urandom_range(0, 7));
      lock       = ($urandom_range(0, 7) == 0);
      hold_req   = ($urandom_range(0, 5) == 0);
      spawn_ack  = ($urandom_range(0, 2) == 0);
`ifdef PIECE_DISPATCHER_STATS_EN
      stats_sel  = PW'($urandom_range(0, 7));
      stats_clr  = ($urandom_range(0, 39) == 0);
`endif
      cycle();
      checks++; if (next_ready !== (m_phase == 0)) begin failures++; $display("FAIL rand_next_ready cyc=%0d got=%b exp=%b", c, next_ready, (m_phase == 0)); end
      checks++; if (spawn_valid !== (m_phase == 1)) begin failures++; $display("FAIL rand_spawn_valid cyc=%0d got=%b exp=%b", c, spawn_valid, (m_phase == 1)); end
      checks++; if (active_piece !== m_active) begin failures++; $display("FAIL rand_active cyc=%0d got=%0d exp=%0d", c, active_piece, m_active); end
      checks++; if (hold_piece !== m_hold) begin failures++; $display("FAIL rand_hold cyc=%0d got=%0d exp=%0d", c, hold_piece, m_hold); end
      checks++; if (hold_used !== m_used) begin failures++; $display("FAIL rand_hold_used cyc=%0d got=%b exp=%b", c, hold_used, m_used); end
`ifdef PIECE_DISPATCHER_STATS_EN
      checks++; if (stats_count !== m_stat_q) begin failures++; $display("FAIL rand_stats cyc=%0d got=%0d exp=%0d", c, stats_count, m_stat_q); end
`endif
    end
    next_valid = 1'b0; lock = 1'b0; hold_req = 1'b0; spawn_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_spawn();
    test_hold_empty();
    test_swap();
    test_lock_and_hold();
    test_ack_stall_and_reset();
`ifdef PIECE_DISPATCHER_STATS_EN
    test_stats();
`endif
    test_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
